// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-op encoding and the logic-unit handshake states.
package alu_pkg;

    // Width of the op select field; the encoding below needs exactly 2 bits.
    localparam int LOGIC_OP_W = 2;

    typedef enum logic [LOGIC_OP_W-1:0] {
        LOGIC_AND = 2'b00,
        LOGIC_OR  = 2'b01,
        LOGIC_XOR = 2'b10,
        LOGIC_NOR = 2'b11
    } logic_op_t;

    // Occupancy of the main (M) and skid (S) registers.
    typedef enum logic [1:0] {
        BLU_EMPTY = 2'b00,  // M empty, S empty
        BLU_ONE   = 2'b01,  // M full,  S empty
        BLU_TWO   = 2'b10   // M full,  S full
    } blu_state_t;

endpackage : alu_pkg

// File: rtl/bitwise_logic_core.sv
// Combinational WIDTH-bit logic core: AND / OR / XOR / NOR, bit-sliced so
// every result bit depends only on the same bit of each operand.
module bitwise_logic_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic_op_t        op,
    output logic [WIDTH-1:0] y
);

    // One slice per bit; NOR is the complement of OR within the slice, so
    // the full-width result is ~(a|b) with no stray upper bits.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y[i] = (op == LOGIC_AND) ? (a[i] & b[i]) :
                      (op == LOGIC_OR)  ? (a[i] | b[i]) :
                      (op == LOGIC_XOR) ? (a[i] ^ b[i]) :
                                          ~(a[i] | b[i]);
    end

endmodule : bitwise_logic_core

// File: rtl/bitwise_logic_unit.sv
// Registered logic unit with valid/ready on both sides and a 2-entry skid
// buffer (M drives the output, S catches one extra result). in_ready comes
// straight from a flop so no combinational ready path crosses this stage.
module bitwise_logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = LOGIC_OP_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_zero
);

    blu_state_t       state, state_nxt;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] m_data, s_data;
    logic             m_zero;
    logic             in_ready_q;
    logic             acc, prd;
    logic             load_m, load_s, move_s;

    bitwise_logic_core #(.WIDTH(WIDTH)) u_core (
        .a  (input_a),
        .b  (input_b),
        .op (logic_op_t'(op)),
        .y  (y)
    );

    assign acc       = in_valid && in_ready_q;
    assign out_valid = (state != BLU_EMPTY);
    assign prd       = out_valid && out_ready;
    assign in_ready  = in_ready_q;
    assign out       = m_data;
    assign out_zero  = m_zero;

    // Next occupancy and which register loads on this edge.
    always_comb begin
        state_nxt = state;
        load_m    = 1'b0;
        load_s    = 1'b0;
        move_s    = 1'b0;
        unique case (state)
            BLU_EMPTY: begin
                if (acc) begin
                    state_nxt = BLU_ONE;
                    load_m    = 1'b1;
                end
            end
            BLU_ONE: begin
                if (acc && prd) begin
                    load_m    = 1'b1;
                end else if (acc) begin
                    state_nxt = BLU_TWO;
                    load_s    = 1'b1;
                end else if (prd) begin
                    state_nxt = BLU_EMPTY;
                end
            end
            BLU_TWO: begin
                // in_ready is low here, so only a produce can happen.
                if (prd) begin
                    state_nxt = BLU_ONE;
                    move_s    = 1'b1;
                end
            end
            default: state_nxt = BLU_EMPTY;
        endcase
    end

    // State register and the registered ready (low exactly while S is full).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= BLU_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != BLU_TWO);
        end
    end

    // Data registers; they only load on an accept or a skid drain, so
    // operand X while in_valid=0 never reaches M or S. The zero flag is
    // registered alongside M so it reads 0 out of reset even though out=0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_data <= '0;
            m_zero <= 1'b0;
            s_data <= '0;
        end else begin
            if (load_m) begin
                m_data <= y;
                m_zero <= ~|y;
            end else if (move_s) begin
                m_data <= s_data;
                m_zero <= ~|s_data;
            end
            if (load_s) begin
                s_data <= y;
            end
        end
    end

endmodule : bitwise_logic_unit

// File: tb/tb_bitwise_logic_unit.sv
// Directed and random checks of bitwise_logic_unit at WIDTH=32 and WIDTH=8.
module tb_bitwise_logic_unit;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // WIDTH=32 instance
    logic        iv32, ir32, ov32, rdy32, oz32;
    logic [31:0] a32, b32, o32;
    logic [1:0]  op32;
    // WIDTH=8 instance
    logic        iv8, ir8, ov8, rdy8, oz8;
    logic [7:0]  a8, b8, o8;
    logic [1:0]  op8;

    int errors = 0;
    int checks = 0;

    bitwise_logic_unit #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset),
        .in_valid(iv32), .in_ready(ir32),
        .input_a(a32), .input_b(b32), .op(op32),
        .out_valid(ov32), .out_ready(rdy32),
        .out(o32), .out_zero(oz32)
    );

    bitwise_logic_unit #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(iv8), .in_ready(ir8),
        .input_a(a8), .input_b(b8), .op(op8),
        .out_valid(ov8), .out_ready(rdy8),
        .out(o8), .out_zero(oz8)
    );

    // Reference for the random test only.
    function automatic logic [7:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] o);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        #2;
        checks++;
        if (ir32 !== 1'b1 || ov32 !== 1'b0 || o32 !== 32'h0 || oz32 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async32: ir=%b ov=%b out=%h z=%b, want 1 0 0 0", ir32, ov32, o32, oz32);
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if (ir32 !== 1'b1 || ov32 !== 1'b0 || o32 !== 32'h0 || oz32 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle32: ir=%b ov=%b out=%h z=%b, want 1 0 0 0", ir32, ov32, o32, oz32);
        end
        checks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || o8 !== 8'h0 || oz8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle8: ir=%b ov=%b out=%h z=%b, want 1 0 0 0", ir8, ov8, o8, oz8);
        end
    endtask

    task automatic test_all_ops;
        logic [31:0] exp [4];
        exp[0] = 32'h00F0_1200;
        exp[1] = 32'hFFF0_FF34;
        exp[2] = 32'hFF00_ED34;
        exp[3] = 32'h000F_00CB;
        @(posedge clock);
        #1;
        rdy32 = 1'b1; iv32 = 1'b1;
        a32 = 32'hF0F0_1234; b32 = 32'h0FF0_FF00; op32 = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            if (i < 3) op32 = 2'(i + 1);
            else       iv32 = 1'b0;
            @(negedge clock);
            checks++;
            if (ov32 !== 1'b1 || o32 !== exp[i] || oz32 !== 1'b0 || ir32 !== 1'b1) begin
                errors++;
                $display("FAIL op%0d: ov=%b out=%h z=%b ir=%b, want 1 %h 0 1", i, ov32, o32, oz32, ir32, exp[i]);
            end
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL ops_drain: ov=%b, want 0", ov32);
        end
    endtask

    task automatic test_zero_flag;
        @(posedge clock);
        #1;
        iv32 = 1'b1; a32 = 32'hAAAA_AAAA; b32 = 32'h5555_5555; op32 = 2'b00;
        @(posedge clock);
        #1 iv32 = 1'b0;
        @(negedge clock);
        checks++;
        if (ov32 !== 1'b1 || o32 !== 32'h0 || oz32 !== 1'b1) begin
            errors++;
            $display("FAIL zero_flag: ov=%b out=%h z=%b, want 1 0 1", ov32, o32, oz32);
        end
        @(posedge clock);
    endtask

    task automatic test_backpressure;
        @(posedge clock);
        #1;
        rdy32 = 1'b0; iv32 = 1'b1; a32 = 32'd1; b32 = 32'd3; op32 = 2'b00;
        @(posedge clock);
        #1;
        a32 = 32'd4; b32 = 32'd8; op32 = 2'b01;
        @(negedge clock);
        checks++;
        if (ir32 !== 1'b1 || ov32 !== 1'b1 || o32 !== 32'd1) begin
            errors++;
            $display("FAIL bp_first: ir=%b ov=%b out=%h, want 1 1 1", ir32, ov32, o32);
        end
        @(posedge clock);
        #1 iv32 = 1'b0;
        @(negedge clock);
        checks++;
        if (ir32 !== 1'b0 || ov32 !== 1'b1 || o32 !== 32'd1) begin
            errors++;
            $display("FAIL bp_full: ir=%b ov=%b out=%h, want 0 1 1", ir32, ov32, o32);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (ir32 !== 1'b0 || o32 !== 32'd1 || oz32 !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: ir=%b out=%h z=%b, want 0 1 0", ir32, o32, oz32);
        end
        @(posedge clock);
        #1 rdy32 = 1'b1;
        @(negedge clock);
        checks++;
        if (ov32 !== 1'b1 || o32 !== 32'd1) begin
            errors++;
            $display("FAIL bp_head: ov=%b out=%h, want 1 1", ov32, o32);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (ov32 !== 1'b1 || o32 !== 32'hC || ir32 !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: ov=%b out=%h ir=%b, want 1 c 1", ov32, o32, ir32);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: ov=%b, want 0", ov32);
        end
    endtask

    task automatic test_stress8;
        logic [7:0] q[$];
        logic [7:0] exp;
        int sent = 0, recv = 0, cyc = 0;
        logic prev_rdy = 1'b0;
        while (recv < 1000 && cyc < 20000) begin
            @(posedge clock);
            #1;
            cyc++;
            iv8  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            rdy8 = 1'($urandom_range(0, 1));
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            op8  = 2'($urandom);
            @(negedge clock);
            if (prev_rdy) begin
                checks++;
                if (ir8 !== 1'b1) begin
                    errors++;
                    $display("FAIL stress_stall cyc%0d: ir=%b, want 1", cyc, ir8);
                end
            end
            if (ov8 && rdy8) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stress_extra cyc%0d: out=%h with nothing expected", cyc, o8);
                end else begin
                    exp = q.pop_front();
                    if (o8 !== exp || oz8 !== (exp == 8'h0)) begin
                        errors++;
                        $display("FAIL stress_data #%0d: out=%h z=%b, want %h %b", recv, o8, oz8, exp, exp == 8'h0);
                    end
                end
                recv++;
            end
            if (iv8 && ir8) begin
                q.push_back(ref8(a8, b8, op8));
                sent++;
            end
            prev_rdy = rdy8;
        end
        iv8 = 1'b0; rdy8 = 1'b0;
        checks++;
        if (recv != 1000 || q.size() != 0) begin
            errors++;
            $display("FAIL stress_count: received %0d left %0d, want 1000 0", recv, q.size());
        end
    endtask

    task automatic test_async_reset_two;
        @(posedge clock);
        #1;
        rdy32 = 1'b0; iv32 = 1'b1; a32 = 32'h0000_0011; b32 = 32'h0000_0022; op32 = 2'b01;
        repeat (2) @(posedge clock);
        #1 iv32 = 1'b0;
        @(negedge clock);
        checks++;
        if (ir32 !== 1'b0 || ov32 !== 1'b1) begin
            errors++;
            $display("FAIL ar_setup: ir=%b ov=%b, want 0 1", ir32, ov32);
        end
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (ir32 !== 1'b1 || ov32 !== 1'b0 || o32 !== 32'h0 || oz32 !== 1'b0) begin
            errors++;
            $display("FAIL ar_immediate: ir=%b ov=%b out=%h z=%b, want 1 0 0 0", ir32, ov32, o32, oz32);
        end
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        rdy32 = 1'b1; iv32 = 1'b1; a32 = 32'h0000_00FF; b32 = 32'h0000_000F; op32 = 2'b10;
        @(posedge clock);
        #1 iv32 = 1'b0;
        @(negedge clock);
        checks++;
        if (ov32 !== 1'b1 || o32 !== 32'h0000_00F0 || oz32 !== 1'b0) begin
            errors++;
            $display("FAIL ar_next: ov=%b out=%h z=%b, want 1 f0 0", ov32, o32, oz32);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL ar_no_stale: ov=%b out=%h, want ov 0", ov32, o32);
        end
    endtask

    initial begin
        iv32 = 1'b0; rdy32 = 1'b0; a32 = '0; b32 = '0; op32 = '0;
        iv8  = 1'b0; rdy8  = 1'b0; a8  = '0; b8  = '0; op8  = '0;
        test_reset();
        test_all_ops();
        test_zero_flag();
        test_backpressure();
        test_stress8();
        test_async_reset_two();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bitwise_logic_unit
